// File: rtl/msk_and_stream.sv
// Masked AND gadget for W independent d-share bit-lanes, streamed with valid/ready.
// Cross terms are registered (with fresh randomness) before the share-wise XOR compression.
module msk_and_stream #(
    parameter int d   = 2,
    parameter int W   = 1,
    parameter int LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [W*d-1:0]               ina,
    input  logic [W*d-1:0]               inb,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W*d*(d-1)/2-1:0]       rnd,
    input  logic                         rnd_valid,
    output logic                         rnd_ready,
    output logic [W*d-1:0]               out,
    output logic                         out_valid,
    input  logic                         out_ready
);
    localparam int n_rnd = d*(d-1)/2;

    // Pair (i,j) and (j,i) share one random bit; diagonal terms are unmasked.
    function automatic int rndIdx(input int k, input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        if (i == j) return 0;
        return k*n_rnd + lo*d - lo*(lo+1)/2 + (hi - 1 - lo);
    endfunction

    logic [W*d*d-1:0] termQ, termD;
    logic             s1ValidQ, s1ValidD;
    logic             s1Advance;
    logic             canAccept;
    logic             accept;
    logic [W*d-1:0]   shareXor;

    assign canAccept = !rst && (!s1ValidQ || s1Advance);
    assign accept    = in_valid && rnd_valid && canAccept;
    assign in_ready  = canAccept && rnd_valid;
    assign rnd_ready = canAccept && in_valid;

    always_comb begin
        termD = termQ;
        if (accept) begin
            for (int k = 0; k < W; k++) begin
                for (int i = 0; i < d; i++) begin
                    for (int j = 0; j < d; j++) begin
                        termD[k*d*d + i*d + j] = (ina[k*d+i] & inb[k*d+j])
                                               ^ ((i != j) ? rnd[rndIdx(k, i, j)] : 1'b0);
                    end
                end
            end
        end
    end

    assign s1ValidD = accept || (s1ValidQ && !s1Advance);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1ValidQ <= 1'b0;
            termQ    <= '0;
        end else begin
            s1ValidQ <= s1ValidD;
            termQ    <= termD;
        end
    end

    always_comb begin
        shareXor = '0;
        for (int k = 0; k < W; k++) begin
            for (int i = 0; i < d; i++) begin
                for (int j = 0; j < d; j++) begin
                    shareXor[k*d+i] = shareXor[k*d+i] ^ termQ[k*d*d + i*d + j];
                end
            end
        end
    end

    generate
        if (LAT == 1) begin : g_lat1
            assign s1Advance = s1ValidQ && out_ready;
            assign out       = shareXor;
            assign out_valid = s1ValidQ;
        end else begin : g_lat2
            logic           s2ValidQ, s2ValidD;
            logic [W*d-1:0] s2DataQ, s2DataD;

            assign s1Advance = s1ValidQ && (!s2ValidQ || out_ready);
            assign s2ValidD  = s1Advance || (s2ValidQ && !out_ready);
            assign s2DataD   = s1Advance ? shareXor : s2DataQ;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2ValidQ <= 1'b0;
                    s2DataQ  <= '0;
                end else begin
                    s2ValidQ <= s2ValidD;
                    s2DataQ  <= s2DataD;
                end
            end

            assign out       = s2DataQ;
            assign out_valid = s2ValidQ;
        end
    endgenerate

endmodule

// File: tb/tb_msk_and_stream.sv
// Bench for msk_and_stream: three configurations checked every cycle against a queue model
// of in-flight items, plus directed vectors with hand-computed results.
module tb_msk_and_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int assertions = 0;
    int failures   = 0;

    // Instance A: d=2 W=1 LAT=1
    logic [1:0]  aIna = '0, aInb = '0, aOut;
    logic [0:0]  aRnd = '0;
    logic        aInValid = 0, aRndValid = 0, aOutReady = 1, aInReady, aRndReady, aOutValid;
    // Instance B: d=3 W=4 LAT=2
    logic [11:0] bIna = '0, bInb = '0, bRnd = '0, bOut;
    logic        bInValid = 0, bRndValid = 0, bOutReady = 1, bInReady, bRndReady, bOutValid;
    // Instance C: d=4 W=2 LAT=1
    logic [7:0]  cIna = '0, cInb = '0, cOut;
    logic [11:0] cRnd = '0;
    logic        cInValid = 0, cRndValid = 0, cOutReady = 1, cInReady, cRndReady, cOutValid;

    msk_and_stream #(.d(2), .W(1), .LAT(1)) uA (
        .clk(clk), .rst(rst), .ina(aIna), .inb(aInb), .in_valid(aInValid), .in_ready(aInReady),
        .rnd(aRnd), .rnd_valid(aRndValid), .rnd_ready(aRndReady),
        .out(aOut), .out_valid(aOutValid), .out_ready(aOutReady));
    msk_and_stream #(.d(3), .W(4), .LAT(2)) uB (
        .clk(clk), .rst(rst), .ina(bIna), .inb(bInb), .in_valid(bInValid), .in_ready(bInReady),
        .rnd(bRnd), .rnd_valid(bRndValid), .rnd_ready(bRndReady),
        .out(bOut), .out_valid(bOutValid), .out_ready(bOutReady));
    msk_and_stream #(.d(4), .W(2), .LAT(1)) uC (
        .clk(clk), .rst(rst), .ina(cIna), .inb(cInb), .in_valid(cInValid), .in_ready(cInReady),
        .rnd(cRnd), .rnd_valid(cRndValid), .rnd_ready(cRndReady),
        .out(cOut), .out_valid(cOutValid), .out_ready(cOutReady));

    logic [63:0] expQ [3][$];
    logic [63:0] andQ [3][$];
    int          accQ [3][$];
    bit          lastRst [3];
    int          bXfer = 0, bFirst = 0, bLast = 0;

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Share i of a lane is the XOR over j of a_i&b_j masked by r(i,j).
    function automatic logic [63:0] modelOut(input int dd, input int ww,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] r);
        logic [63:0] res;
        int nr, lo, hi;
        logic t;
        res = '0;
        nr  = dd*(dd-1)/2;
        for (int k = 0; k < ww; k++)
            for (int i = 0; i < dd; i++)
                for (int j = 0; j < dd; j++) begin
                    t = a[k*dd+i] & b[k*dd+j];
                    if (i != j) begin
                        lo = (i < j) ? i : j;
                        hi = (i < j) ? j : i;
                        t  = t ^ r[k*nr + lo*dd - lo*(lo+1)/2 + (hi-1-lo)];
                    end
                    res[k*dd+i] = res[k*dd+i] ^ t;
                end
        return res;
    endfunction

    function automatic logic [63:0] lanesXor(input int dd, input int ww, input logic [63:0] v);
        logic [63:0] res;
        res = '0;
        for (int k = 0; k < ww; k++)
            for (int s = 0; s < dd; s++)
                res[k] = res[k] ^ v[k*dd+s];
        return res;
    endfunction

    function automatic logic [63:0] modelAnd(input int dd, input int ww,
                                             input logic [63:0] a, input logic [63:0] b);
        return lanesXor(dd, ww, a) & lanesXor(dd, ww, b);
    endfunction

    // Per-cycle compare: handshakes follow pipeline occupancy, head item appears LAT cycles after accept.
    task automatic checkOutput(input int id, input int dd, input int ww, input int lat,
                               input logic inV, input logic rndV, input logic outR,
                               input logic inR, input logic rndR, input logic outV,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] r, input logic [63:0] o);
        int occ;
        bit canAcc, expV;
        string tag;
        tag = $sformatf("u%0d", id);
        if (rst) begin
            checkValue({tag, ".in_ready_rst"}, 64'(inR), 64'(0));
            checkValue({tag, ".rnd_ready_rst"}, 64'(rndR), 64'(0));
            expQ[id].delete();
            andQ[id].delete();
            accQ[id].delete();
            lastRst[id] = 1;
            return;
        end
        if (lastRst[id]) checkValue({tag, ".out_after_rst"}, o, 64'(0));
        lastRst[id] = 0;
        occ    = expQ[id].size();
        canAcc = (occ < lat) || outR;
        checkValue({tag, ".in_ready"}, 64'(inR), 64'(rndV && canAcc));
        checkValue({tag, ".rnd_ready"}, 64'(rndR), 64'(inV && canAcc));
        expV = (occ > 0) && (cyc - accQ[id][0] >= lat);
        checkValue({tag, ".out_valid"}, 64'(outV), 64'(expV));
        if (outV && occ > 0) begin
            checkValue({tag, ".out"}, o, expQ[id][0]);
            checkValue({tag, ".lane_and"}, lanesXor(dd, ww, o), andQ[id][0]);
        end
        if (outV && outR && occ > 0) begin
            void'(expQ[id].pop_front());
            void'(andQ[id].pop_front());
            void'(accQ[id].pop_front());
        end
        if (inV && rndV && canAcc) begin
            expQ[id].push_back(modelOut(dd, ww, a, b, r));
            andQ[id].push_back(modelAnd(dd, ww, a, b));
            accQ[id].push_back(cyc);
        end
    endtask

    always @(negedge clk) begin
        checkOutput(0, 2, 1, 1, aInValid, aRndValid, aOutReady, aInReady, aRndReady, aOutValid,
                    64'(aIna), 64'(aInb), 64'(aRnd), 64'(aOut));
        checkOutput(1, 3, 4, 2, bInValid, bRndValid, bOutReady, bInReady, bRndReady, bOutValid,
                    64'(bIna), 64'(bInb), 64'(bRnd), 64'(bOut));
        checkOutput(2, 4, 2, 1, cInValid, cRndValid, cOutReady, cInReady, cRndReady, cOutValid,
                    64'(cIna), 64'(cInb), 64'(cRnd), 64'(cOut));
        if (!rst && bOutValid && bOutReady) begin
            if (bXfer == 0) bFirst = cyc;
            bLast = cyc;
            bXfer++;
        end
    end

    // Drives one instance just after the next rising edge.
    task automatic applyStimulus(input int id, input logic inV, input logic rndV, input logic outR,
                                 input logic [63:0] a, input logic [63:0] b, input logic [63:0] r);
        @(posedge clk);
        #1;
        case (id)
            0: begin aInValid = inV; aRndValid = rndV; aOutReady = outR;
                     aIna = a[1:0]; aInb = b[1:0]; aRnd = r[0:0]; end
            1: begin bInValid = inV; bRndValid = rndV; bOutReady = outR;
                     bIna = a[11:0]; bInb = b[11:0]; bRnd = r[11:0]; end
            default: begin cInValid = inV; cRndValid = rndV; cOutReady = outR;
                     cIna = a[7:0]; cInb = b[7:0]; cRnd = r[11:0]; end
        endcase
    endtask

    logic [7:0]  mapExp [12] = '{8'h03, 8'h05, 8'h09, 8'h06, 8'h0A, 8'h0C,
                                 8'h30, 8'h50, 8'h90, 8'h60, 8'hA0, 8'hC0};
    logic [63:0] bpA [3], bpB [3], bpR [3];
    logic [11:0] held;
    int          startCyc, idx;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checkValue("reset.a_valid", 64'(aOutValid), 64'(0));
        checkValue("reset.b_valid", 64'(bOutValid), 64'(0));
        checkValue("reset.c_valid", 64'(cOutValid), 64'(0));

        // Basic: a=(1,0), b=(0,1), r=1 -> shares (0,1)
        checkValue("model.basic", modelOut(2, 1, 64'h1, 64'h2, 64'h1), 64'h2);
        applyStimulus(0, 1, 1, 1, 64'h1, 64'h2, 64'h1);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        checkValue("basic.out_valid", 64'(aOutValid), 64'(1));
        checkValue("basic.out", 64'(aOut), 64'h2);
        checkValue("basic.share_xor", 64'(^aOut), 64'(1));

        // Starved randomness, then release: a=b=(1,1), r=1 -> shares (1,1)
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 1, 0, 1, 64'h3, 64'h3, 64'h0);
            @(negedge clk);
            checkValue("starve.in_ready", 64'(aInReady), 64'(0));
            checkValue("starve.out_valid", 64'(aOutValid), 64'(0));
        end
        applyStimulus(0, 1, 1, 1, 64'h3, 64'h3, 64'h1);
        @(negedge clk);
        checkValue("starve.release_ready", 64'(aInReady), 64'(1));
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        checkValue("starve.out_valid_after", 64'(aOutValid), 64'(1));
        checkValue("starve.out", 64'(aOut), 64'h3);

        // Randomness mapping sweep with zero operands
        for (int bit_i = 0; bit_i < 12; bit_i++) begin
            checkValue($sformatf("model.map%0d", bit_i),
                       modelOut(4, 2, 0, 0, 64'(1) << bit_i), 64'(mapExp[bit_i]));
            applyStimulus(2, 1, 1, 1, 0, 0, 64'(1) << bit_i);
            applyStimulus(2, 0, 0, 1, 0, 0, 0);
            @(negedge clk);
            checkValue($sformatf("map%0d.out", bit_i), 64'(cOut), 64'(mapExp[bit_i]));
        end

        // Throughput: 16 back-to-back operands
        bXfer = 0;
        applyStimulus(1, 1, 1, 1, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                      {$urandom(), $urandom()});
        startCyc = cyc;
        for (int n = 1; n < 16; n++)
            applyStimulus(1, 1, 1, 1, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                          {$urandom(), $urandom()});
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        repeat (4) @(negedge clk);
        checkValue("thru.count", 64'(bXfer), 64'(16));
        checkValue("thru.consecutive", 64'(bLast - bFirst), 64'(15));
        checkValue("thru.first_latency", 64'(bFirst - startCyc), 64'(2));

        // Backpressure: three items, out_ready low for four cycles
        for (int n = 0; n < 3; n++) begin
            bpA[n] = {$urandom(), $urandom()};
            bpB[n] = {$urandom(), $urandom()};
            bpR[n] = {$urandom(), $urandom()};
        end
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            if (idx < 3) applyStimulus(1, 1, 1, 0, bpA[idx], bpB[idx], bpR[idx]);
            else         applyStimulus(1, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (c == 2) held = bOut;
            if (c == 3) begin
                checkValue("bp.in_ready_full", 64'(bInReady), 64'(0));
                checkValue("bp.out_valid", 64'(bOutValid), 64'(1));
                checkValue("bp.stable", 64'(bOut), 64'(held));
            end
            if (bInValid && bInReady) idx++;
        end
        bXfer = 0;
        for (int c = 0; c < 8; c++) begin
            if (idx < 3) applyStimulus(1, 1, 1, 1, bpA[idx], bpB[idx], bpR[idx]);
            else         applyStimulus(1, 0, 0, 1, 0, 0, 0);
            @(negedge clk);
            if (bInValid && bInReady) idx++;
        end
        checkValue("bp.all_accepted", 64'(idx), 64'(3));
        checkValue("bp.count", 64'(bXfer), 64'(3));
        checkValue("bp.consecutive", 64'(bLast - bFirst), 64'(2));

        // Reset mid-stream with both stages full
        applyStimulus(1, 1, 1, 0, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 64'hABC);
        applyStimulus(1, 1, 1, 0, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 64'h123);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkValue("rstmid.full", 64'(bOutValid), 64'(1));
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checkValue("rstmid.out_valid", 64'(bOutValid), 64'(0));
        checkValue("rstmid.out", 64'(bOut), 64'(0));
        applyStimulus(1, 1, 1, 1, 64'hFFF, 64'hFFF, 64'h5A5);
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        checkValue("rstmid.lat1", 64'(bOutValid), 64'(0));
        @(negedge clk);
        checkValue("rstmid.lat2", 64'(bOutValid), 64'(1));

        repeat (3) @(negedge clk);
        checkValue("drain.empty", 64'(expQ[0].size() + expQ[1].size() + expQ[2].size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
